// File: rtl/servo_pwm_drive.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_drive
// Brief    : Shared 21-bit period counter plus two servo pulse-train channels.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_drive #(
    parameter int unsigned MAX_COUNT = 2000000,
    parameter int unsigned PULSE_FWD = 200000,
    parameter int unsigned PULSE_REV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_reset,
    output logic [20:0] count_out,
    output logic        period_start,
    input  logic        motor_l_reset,
    input  logic        motor_l_direction,
    input  logic        motor_r_reset,
    input  logic        motor_r_direction,
    output logic        pwm_l,
    output logic        pwm_r,
    output logic        busy_l,
    output logic        busy_r
);

    localparam logic [20:0] C_MAX = 21'(MAX_COUNT);
    localparam logic [20:0] C_FWD = 21'(PULSE_FWD);
    localparam logic [20:0] C_REV = 21'(PULSE_REV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        LOW   = 2'd2
    } state_t;

    logic [20:0] cnt_q;
    logic [20:0] cnt_d;
    logic        start;

    always_comb begin
        cnt_d = cnt_q + 21'd1;
        if (count_reset || (cnt_q == C_MAX)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by reset so the strobe stays quiet while the block is held in reset.
    assign start        = reset && (cnt_q == '0) && !count_reset;
    assign count_out    = cnt_q;
    assign period_start = start;

    logic [1:0] ch_rst;
    logic [1:0] ch_dir;
    logic [1:0] ch_pwm;
    logic [1:0] ch_busy;

    assign ch_rst = {motor_r_reset, motor_l_reset};
    assign ch_dir = {motor_r_direction, motor_l_direction};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_ch
            state_t      state_q;
            state_t      state_d;
            logic [20:0] width_q;
            logic [20:0] width_d;
            logic        pwm_q;
            logic        busy_q;

            always_comb begin
                state_d = state_q;
                width_d = width_q;
                case (state_q)
                    IDLE, LOW: begin
                        if (start) begin
                            if (!ch_rst[i]) begin
                                state_d = PULSE;
                                width_d = ch_dir[i] ? C_FWD : C_REV;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                    PULSE: begin
                        // A counter clear invalidates the timing, so the pulse is aborted.
                        if (count_reset || (cnt_q == width_q)) begin
                            state_d = LOW;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q <= IDLE;
                    width_q <= '0;
                    pwm_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    width_q <= width_d;
                    pwm_q   <= (state_d == PULSE);
                    busy_q  <= (state_d == PULSE);
                end
            end

            assign ch_pwm[i]  = pwm_q;
            assign ch_busy[i] = busy_q;
        end
    endgenerate

    assign pwm_l  = ch_pwm[0];
    assign pwm_r  = ch_pwm[1];
    assign busy_l = ch_busy[0];
    assign busy_r = ch_busy[1];

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_drive.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pwm_drive
// Brief    : Directed bench for servo_pwm_drive (MAX_COUNT=99, REV=10, FWD=20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_drive;

    logic        clk = 1'b0;
    logic        reset;
    logic        count_reset;
    logic [20:0] count_out;
    logic        period_start;
    logic        motor_l_reset;
    logic        motor_l_direction;
    logic        motor_r_reset;
    logic        motor_r_direction;
    logic        pwm_l;
    logic        pwm_r;
    logic        busy_l;
    logic        busy_r;

    int n_cmp = 0;
    int n_bad = 0;

    servo_pwm_drive #(
        .MAX_COUNT(99),
        .PULSE_FWD(20),
        .PULSE_REV(10)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .count_reset      (count_reset),
        .count_out        (count_out),
        .period_start     (period_start),
        .motor_l_reset    (motor_l_reset),
        .motor_l_direction(motor_l_direction),
        .motor_r_reset    (motor_r_reset),
        .motor_r_direction(motor_r_direction),
        .pwm_l            (pwm_l),
        .pwm_r            (pwm_r),
        .busy_l           (busy_l),
        .busy_r           (busy_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // k is the cycle index within a period, 1..100; k = 100 lands back on cnt = 0.
    // wl/wr are the expected pulse widths of this period (0 = no pulse).
    task automatic run_period(input int from_k, input int to_k, input int wl, input int wr);
        for (int k = from_k; k <= to_k; k++) begin
            logic el;
            logic er;
            tick();
            el = (k < 100) && (k <= wl);
            er = (k < 100) && (k <= wr);
            chk($sformatf("cnt k=%0d", k), 32'(count_out), 32'(k % 100));
            chk($sformatf("pwm_l k=%0d", k), 32'(pwm_l), 32'(el));
            chk($sformatf("pwm_r k=%0d", k), 32'(pwm_r), 32'(er));
            chk($sformatf("busy_l k=%0d", k), 32'(busy_l), 32'(el));
            chk($sformatf("busy_r k=%0d", k), 32'(busy_r), 32'(er));
            chk($sformatf("pstart k=%0d", k), 32'(period_start), 32'(k == 100));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b0;
        count_reset       = 1'b0;
        motor_l_reset     = 1'b0;
        motor_l_direction = 1'b1;
        motor_r_reset     = 1'b0;
        motor_r_direction = 1'b0;

        #23;
        chk("rst cnt", 32'(count_out), 32'd0);
        chk("rst pwm_l", 32'(pwm_l), 32'd0);
        chk("rst pwm_r", 32'(pwm_r), 32'd0);
        chk("rst busy_l", 32'(busy_l), 32'd0);
        chk("rst busy_r", 32'(busy_r), 32'd0);
        chk("rst pstart", 32'(period_start), 32'd0);

        // 1: basic periods, left FWD (20), right REV (10)
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t1 pstart at release", 32'(period_start), 32'd1);
        run_period(1, 100, 20, 10);
        run_period(1, 100, 20, 10);

        // 2: direction change mid-pulse only affects the next period
        run_period(1, 5, 20, 10);
        motor_l_direction = 1'b0;
        run_period(6, 100, 20, 10);
        run_period(1, 50, 10, 10);
        motor_l_direction = 1'b1;
        run_period(51, 100, 10, 10);

        // 3: channel disable mid-pulse does not truncate; next period silent
        run_period(1, 3, 20, 10);
        motor_l_reset = 1'b1;
        run_period(4, 100, 20, 10);
        run_period(1, 50, 0, 10);
        motor_l_reset = 1'b0;
        run_period(51, 100, 0, 10);

        // 4: one-cycle count_reset at cnt = 7 aborts both pulses
        run_period(1, 7, 20, 10);
        count_reset = 1'b1;
        #1;
        chk("t4 pstart during clr", 32'(period_start), 32'd0);
        tick();
        count_reset = 1'b0;
        chk("t4 cnt cleared", 32'(count_out), 32'd0);
        chk("t4 pwm_l abort", 32'(pwm_l), 32'd0);
        chk("t4 pwm_r abort", 32'(pwm_r), 32'd0);
        chk("t4 busy_l abort", 32'(busy_l), 32'd0);
        run_period(1, 100, 20, 10);

        // 5: count_reset held for 300 cycles mid-pulse
        run_period(1, 12, 20, 10);
        count_reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk($sformatf("t5 cnt i=%0d", i), 32'(count_out), 32'd0);
            chk($sformatf("t5 pwm_l i=%0d", i), 32'(pwm_l), 32'd0);
            chk($sformatf("t5 pwm_r i=%0d", i), 32'(pwm_r), 32'd0);
            chk($sformatf("t5 pstart i=%0d", i), 32'(period_start), 32'd0);
        end
        count_reset = 1'b0;
        #1;
        chk("t5 pstart on release", 32'(period_start), 32'd1);
        run_period(1, 12, 20, 10);

        // 6: asynchronous reset mid-pulse at cnt = 12
        #2;
        reset = 1'b0;
        #1;
        chk("t6 async cnt", 32'(count_out), 32'd0);
        chk("t6 async pwm_l", 32'(pwm_l), 32'd0);
        chk("t6 async pwm_r", 32'(pwm_r), 32'd0);
        chk("t6 async busy_l", 32'(busy_l), 32'd0);
        chk("t6 async busy_r", 32'(busy_r), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_period(1, 100, 20, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
